hough_vote_gen: RTL
===================

# hough_vote_gen

Upstream vote generator for the Hough accumulator memory. Accepts one edge-pixel coordinate (x, y) per handshake. Sweeps phi = 0..179°, computes rho = x·cos(phi) + y·sin(phi) in fixed point, and maps rho to an accumulator row index. For each vote it drives the accumulator's r/phi inputs and its 4-bit control word, in the sequence latch → read-increment → write.

## Interface
Parameters:
- MSB_X, 9, msb of pixel x coordinate (image up to 1024 wide)
- MSB_Y, 8, msb of pixel y coordinate (image up to 512 high)
- MSB_PHI, 7, msb of phi output
- MSB_R, 11, msb of r output
- PHI_MAX, 179, last phi index swept (degrees)
- R_OFFSET, 1024, bias added to signed rho before scaling
- R_SHIFT, 1, right shift applied after biasing
- MSB_CTRL_MEMO, 3, msb of accumulator control word

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- pix_valid  in  1  pixel coordinate valid
- pix_x  in  MSB_X+1  pixel column, unsigned
- pix_y  in  MSB_Y+1  pixel row, unsigned
- pix_ready  out  1  block can accept a pixel
- r  out  MSB_R+1  accumulator row index, registered
- phi  out  MSB_PHI+1  accumulator column index, registered
- ctrl_memo  out  MSB_CTRL_MEMO+1  {wR_buf, wPhi_buf, wCnt_buf, we}, registered
- busy  out  1  sweep in progress
- vote_done  out  1  one-cycle pulse after the last vote of a pixel
- pix_cnt  out  20  accepted-pixel counter, wraps at 2^20

## Operation
- Trig ROM: 91-entry quarter-wave table Q[k] = round(16384·sin k°), k = 0..90, signed 16-bit Q1.14; Q[90] = 16384. Implemented as a synthesizable case ROM.
- sin(phi) = Q[phi] for phi ≤ 90, otherwise Q[180−phi].
- cos(phi) = Q[90−phi] for phi ≤ 90, otherwise −Q[phi−90].
- Arithmetic: products x·cos and y·sin are 27-bit signed; their sum is 28-bit signed.
- rho = (sum + 8192) >>> 14, i.e. round half up.
- rho is clamped to [−R_OFFSET, R_OFFSET−1].
- r = (rho + R_OFFSET) >> R_SHIFT, zero-extended to MSB_R+1. Defaults map r into 0..1023.
- FSM states IDLE, CALC, LATCH, INC, WR.
  - IDLE: pix_ready = 1. On pix_valid & pix_ready, capture x and y, set phi_cnt = 0, increment pix_cnt, go to CALC.
  - CALC: register r and phi from phi_cnt; ctrl_memo = 0000; go to LATCH.
  - LATCH: ctrl_memo = 1100; go to INC.
  - INC: ctrl_memo = 0010; go to WR.
  - WR: ctrl_memo = 0001. If phi_cnt == PHI_MAX, go to IDLE and pulse vote_done. Otherwise increment phi_cnt and go to CALC.
- r and phi hold their values from CALC through WR and hold the last vote's values while in IDLE.
- pix_x and pix_y are sampled only at acceptance; changes during a sweep are ignored.
- pix_valid while busy: no effect. The upstream holds the pixel until pix_ready.
- busy = 1 in every state except IDLE.

## Timing
- Reset values: r = 0, phi = 0, ctrl_memo = 0000, busy = 0, vote_done = 0, pix_cnt = 0; state = IDLE.
- pix_ready = (state == IDLE) & ~reset, so it is 0 during the reset cycle.
- Reset mid-sweep: next cycle is IDLE with ctrl_memo = 0000. No further votes are issued and no write strobe follows. The partial pixel is discarded and pix_cnt is cleared.
- Per-pixel schedule, acceptance edge = cycle 0:
  - Cycle 1: CALC.
  - Cycle 2: LATCH, with r/phi for phi = 0 valid.
  - Cycle 3: INC.
  - Cycle 4: WR.
  - Each vote takes 4 cycles; the final WR (phi = 179) is in cycle 720.
- Cycle 721: IDLE, vote_done = 1, pix_ready = 1.
- A pixel presented in cycle 721 is accepted, giving back-to-back throughput of 1 pixel per 721 cycles.
- At most one ctrl_memo bit group is active per cycle. we is never asserted in the same cycle as wR_buf or wCnt_buf.

## Test plan
- Reset then pixel (0,0): 180 votes, all with r = 512, phi = 0..179 ascending. ctrl_memo sequence 0000, 1100, 0010, 0001 per vote. vote_done in cycle 721. pix_cnt = 1.
- Pixel (100,0): phi = 0 → r = 562; phi = 90 → r = 512; phi = 179 → r = 462 (rho = −100).
- Pixel (0,200): phi = 90 → r = 612; phi = 0 → r = 512. Pixel (639,479): phi = 37 → rho = 799, r = 911, no clamp.
- Back-to-back: pix_valid held high with two pixels. Second acceptance occurs in cycle 721. pix_ready is low in cycles 1..720. Inputs changed mid-sweep do not alter the r values.
- Reset asserted during INC of phi = 57: next cycle ctrl_memo = 0000, busy = 0, no WR strobe follows. A new pixel is accepted cleanly afterwards, starting again at phi = 0.
- Accumulator integration, with the memory model connected: feed pixels (100,0) twice. Cells (562,0), (512,90) and (462,179) each read 2; all untouched cells read 0.

Source files
------------

// File: rtl/hough_vote_gen.sv
// hough_vote_gen
// Vote generator feeding the Hough accumulator memory. For each accepted
// edge pixel (x, y) it sweeps phi = 0..PHI_MAX degrees and computes
// rho = x*cos(phi) + y*sin(phi) in Q1.14 fixed point. It maps rho to an
// accumulator row r and issues one vote per angle, using the control
// sequence latch -> read-increment -> write.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high
//   pix_valid  pixel coordinate valid
//   pix_x      pixel column, unsigned
//   pix_y      pixel row, unsigned
//   pix_ready  block can accept a pixel (IDLE and not in reset)
//   r          accumulator row index, registered
//   phi        accumulator column index, registered
//   ctrl_memo  {wR_buf, wPhi_buf, wCnt_buf, we}, registered
//   busy       sweep in progress
//   vote_done  one-cycle pulse after the last vote of a pixel
//   pix_cnt    accepted-pixel counter, wraps at 2^20
module hough_vote_gen #(
  parameter int MSB_X         = 9,
  parameter int MSB_Y         = 8,
  parameter int MSB_PHI       = 7,
  parameter int MSB_R         = 11,
  parameter int PHI_MAX       = 179,
  parameter int R_OFFSET      = 1024,
  parameter int R_SHIFT       = 1,
  parameter int MSB_CTRL_MEMO = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_valid,
  input  logic [MSB_X:0]         pix_x,
  input  logic [MSB_Y:0]         pix_y,
  output logic                   pix_ready,
  output logic [MSB_R:0]         r,
  output logic [MSB_PHI:0]       phi,
  output logic [MSB_CTRL_MEMO:0] ctrl_memo,
  output logic                   busy,
  output logic                   vote_done,
  output logic [19:0]            pix_cnt
);

  localparam int PW = MSB_PHI + 1;
  localparam int RW = MSB_R + 1;
  localparam int CW = MSB_CTRL_MEMO + 1;

  localparam logic signed [27:0] RHO_HI   = 28'(R_OFFSET - 1);
  localparam logic signed [27:0] RHO_LO   = 28'(-R_OFFSET);
  localparam logic signed [27:0] RHO_BIAS = 28'(R_OFFSET);
  localparam logic signed [27:0] RHO_RND  = 28'sd8192;

  localparam logic [CW-1:0] CTRL_LATCH = CW'(4'b1100);
  localparam logic [CW-1:0] CTRL_INC   = CW'(4'b0010);
  localparam logic [CW-1:0] CTRL_WR    = CW'(4'b0001);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    LATCH,
    INC,
    WR
  } state_t;

  state_t          state;
  logic [MSB_X:0]  x_reg;
  logic [MSB_Y:0]  y_reg;
  logic [PW-1:0]   phi_cnt;

  // Quarter-wave sine table: round(16384 * sin(k deg)), k = 0..90, Q1.14.
  function automatic logic signed [15:0] q_rom(input logic [PW-1:0] k);
    case (int'(k))
      0:  q_rom = 16'sd0;
      1:  q_rom = 16'sd286;
      2:  q_rom = 16'sd572;
      3:  q_rom = 16'sd857;
      4:  q_rom = 16'sd1143;
      5:  q_rom = 16'sd1428;
      6:  q_rom = 16'sd1713;
      7:  q_rom = 16'sd1997;
      8:  q_rom = 16'sd2280;
      9:  q_rom = 16'sd2563;
      10: q_rom = 16'sd2845;
      11: q_rom = 16'sd3126;
      12: q_rom = 16'sd3406;
      13: q_rom = 16'sd3686;
      14: q_rom = 16'sd3964;
      15: q_rom = 16'sd4240;
      16: q_rom = 16'sd4516;
      17: q_rom = 16'sd4790;
      18: q_rom = 16'sd5063;
      19: q_rom = 16'sd5334;
      20: q_rom = 16'sd5604;
      21: q_rom = 16'sd5872;
      22: q_rom = 16'sd6138;
      23: q_rom = 16'sd6402;
      24: q_rom = 16'sd6664;
      25: q_rom = 16'sd6924;
      26: q_rom = 16'sd7182;
      27: q_rom = 16'sd7438;
      28: q_rom = 16'sd7692;
      29: q_rom = 16'sd7943;
      30: q_rom = 16'sd8192;
      31: q_rom = 16'sd8438;
      32: q_rom = 16'sd8682;
      33: q_rom = 16'sd8923;
      34: q_rom = 16'sd9162;
      35: q_rom = 16'sd9397;
      36: q_rom = 16'sd9630;
      37: q_rom = 16'sd9860;
      38: q_rom = 16'sd10087;
      39: q_rom = 16'sd10311;
      40: q_rom = 16'sd10531;
      41: q_rom = 16'sd10749;
      42: q_rom = 16'sd10963;
      43: q_rom = 16'sd11174;
      44: q_rom = 16'sd11381;
      45: q_rom = 16'sd11585;
      46: q_rom = 16'sd11786;
      47: q_rom = 16'sd11982;
      48: q_rom = 16'sd12176;
      49: q_rom = 16'sd12365;
      50: q_rom = 16'sd12551;
      51: q_rom = 16'sd12733;
      52: q_rom = 16'sd12911;
      53: q_rom = 16'sd13085;
      54: q_rom = 16'sd13255;
      55: q_rom = 16'sd13421;
      56: q_rom = 16'sd13583;
      57: q_rom = 16'sd13741;
      58: q_rom = 16'sd13894;
      59: q_rom = 16'sd14044;
      60: q_rom = 16'sd14189;
      61: q_rom = 16'sd14330;
      62: q_rom = 16'sd14466;
      63: q_rom = 16'sd14598;
      64: q_rom = 16'sd14726;
      65: q_rom = 16'sd14849;
      66: q_rom = 16'sd14968;
      67: q_rom = 16'sd15082;
      68: q_rom = 16'sd15191;
      69: q_rom = 16'sd15296;
      70: q_rom = 16'sd15396;
      71: q_rom = 16'sd15491;
      72: q_rom = 16'sd15582;
      73: q_rom = 16'sd15668;
      74: q_rom = 16'sd15749;
      75: q_rom = 16'sd15826;
      76: q_rom = 16'sd15897;
      77: q_rom = 16'sd15964;
      78: q_rom = 16'sd16026;
      79: q_rom = 16'sd16083;
      80: q_rom = 16'sd16135;
      81: q_rom = 16'sd16182;
      82: q_rom = 16'sd16225;
      83: q_rom = 16'sd16262;
      84: q_rom = 16'sd16294;
      85: q_rom = 16'sd16322;
      86: q_rom = 16'sd16344;
      87: q_rom = 16'sd16362;
      88: q_rom = 16'sd16374;
      89: q_rom = 16'sd16382;
      90: q_rom = 16'sd16384;
      default: q_rom = 16'sd0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // rho datapath for the current phi_cnt (evaluated while in CALC)
  // ---------------------------------------------------------------------------
  logic [PW-1:0]      sin_arg;
  logic [PW-1:0]      cos_arg;
  logic               cos_neg;
  logic signed [15:0] sin_q;
  logic signed [15:0] cos_mag;
  logic signed [15:0] cos_q;
  logic signed [26:0] x_ext;
  logic signed [26:0] y_ext;
  logic signed [26:0] prod_x;
  logic signed [26:0] prod_y;
  logic signed [27:0] acc_sum;
  logic signed [27:0] rho_raw;
  logic signed [27:0] rho_clamped;
  logic signed [27:0] rho_biased;
  logic [RW-1:0]      r_next;

  always_comb begin
    // Fold phi onto the quarter-wave table; cos is negative past 90 deg.
    if (phi_cnt <= PW'(90)) begin
      sin_arg = phi_cnt;
      cos_arg = PW'(90) - phi_cnt;
      cos_neg = 1'b0;
    end else begin
      sin_arg = PW'(180) - phi_cnt;
      cos_arg = phi_cnt - PW'(90);
      cos_neg = 1'b1;
    end

    sin_q   = q_rom(sin_arg);
    cos_mag = q_rom(cos_arg);
    cos_q   = cos_neg ? -cos_mag : cos_mag;

    x_ext  = signed'(27'(x_reg));
    y_ext  = signed'(27'(y_reg));
    prod_x = x_ext * 27'(cos_q);
    prod_y = y_ext * 27'(sin_q);

    // Adding half an LSB before the arithmetic shift rounds half up.
    acc_sum = 28'(prod_x) + 28'(prod_y) + RHO_RND;
    rho_raw = acc_sum >>> 14;

    if (rho_raw > RHO_HI) begin
      rho_clamped = RHO_HI;
    end else if (rho_raw < RHO_LO) begin
      rho_clamped = RHO_LO;
    end else begin
      rho_clamped = rho_raw;
    end

    // Biased value is non-negative, so the shift is a plain divide.
    rho_biased = rho_clamped + RHO_BIAS;
    r_next     = RW'(rho_biased >>> R_SHIFT);
  end

  // ---------------------------------------------------------------------------
  // Sweep FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      phi_cnt   <= '0;
      r         <= '0;
      phi       <= '0;
      ctrl_memo <= '0;
      vote_done <= 1'b0;
      pix_cnt   <= '0;
    end else begin
      vote_done <= 1'b0;
      case (state)
        IDLE: begin
          ctrl_memo <= '0;
          if (pix_valid) begin
            x_reg   <= pix_x;
            y_reg   <= pix_y;
            phi_cnt <= '0;
            pix_cnt <= pix_cnt + 20'd1;
            state   <= CALC;
          end
        end
        CALC: begin
          r         <= r_next;
          phi       <= phi_cnt;
          ctrl_memo <= CTRL_LATCH;
          state     <= LATCH;
        end
        LATCH: begin
          ctrl_memo <= CTRL_INC;
          state     <= INC;
        end
        INC: begin
          ctrl_memo <= CTRL_WR;
          state     <= WR;
        end
        WR: begin
          ctrl_memo <= '0;
          if (phi_cnt == PW'(PHI_MAX)) begin
            vote_done <= 1'b1;
            state     <= IDLE;
          end else begin
            phi_cnt <= phi_cnt + PW'(1);
            state   <= CALC;
          end
        end
        default: begin
          ctrl_memo <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign pix_ready = (state == IDLE) & ~reset;
  assign busy      = (state != IDLE);

endmodule
